// File: rtl/seq_approx_row_divider.sv
// ---------------------------------------------------------------------------
// seq_approx_row_divider
//   Iterative restoring divider: 2W-bit dividend / W-bit divisor. One
//   subtractor row is evaluated per clock and produces one quotient bit,
//   MSB first. Rows i < APPROX_ROWS use approximate cells in columns
//   j < APPROX_COLS (clamped to W); all other cells are exact.
//
//   Optional feature macro: APPROX_DIV_RUNTIME_EXACT_EN
//     When defined, adds input exact_mode. It is sampled on an accepted
//     start; when 1, every cell of that operation is exact.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   exact_mode in   1   (macro only) force exact cells for this operation
//   start      in   1   request, accepted only while ready=1
//   n          in   2W  dividend, sampled on accepted start
//   d          in   W   divisor, sampled on accepted start
//   ready      out  1   idle, can accept start
//   valid      out  1   one-cycle pulse when q/r/dz/ovf are updated
//   q          out  W   quotient
//   r          out  W   remainder
//   dz         out  1   divide-by-zero flag of last operation
//   ovf        out  1   n[2W-1:W] >= d (quotient truncated) of last op
// ---------------------------------------------------------------------------
module seq_approx_row_divider #(
  parameter int W           = 8,
  parameter int APPROX_ROWS = 6,
  parameter int APPROX_COLS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef APPROX_DIV_RUNTIME_EXACT_EN
  input  logic           exact_mode,
`endif
  input  logic           start,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  output logic           ready,
  output logic           valid,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           dz,
  output logic           ovf
);

  localparam int IW = (W > 2) ? $clog2(W) : 1;
  localparam int AC = (APPROX_COLS > W) ? W : APPROX_COLS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_nlo;
  logic [W-1:0]    r_d;
  logic [W-1:0]    r_rem;
  logic [IW-1:0]   r_i;
  logic [W-1:0]    r_qacc;
  logic            r_ovfn;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_r;
  logic            r_dz;
  logic            r_ovf;
  logic            w_exact;
  logic            w_accept;
  logic            w_last;
  logic [W-1:0]    w_x;
  logic [W-1:0]    w_diff;
  logic            w_bout;
  logic            w_qbit;
  logic [W-1:0]    w_rem_nxt;
  logic [W-1:0]    w_q_nxt;

`ifdef APPROX_DIV_RUNTIME_EXACT_EN
  logic r_exact;
  assign w_exact = r_exact;
`else
  assign w_exact = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_i == '0);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (d == '0) ? DONE : RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // One subtractor row: x - d with a per-column exact/approximate cell.
  // The top remainder bit (hi) is shifted out of x; if it was set the
  // true partial remainder exceeds d, so the row always subtracts.
  always_comb begin
    logic bin;
    logic apx;
    w_x    = {r_rem[W-2:0], r_nlo[r_i]};
    w_diff = '0;
    bin    = 1'b0;
    for (int j = 0; j < W; j++) begin
      apx = !w_exact && (int'(r_i) < APPROX_ROWS) && (j < AC);
      if (apx) begin
        w_diff[j] = r_d[j];
        bin       = w_x[j] & r_d[j];
      end else begin
        w_diff[j] = w_x[j] ^ r_d[j] ^ bin;
        bin       = (~w_x[j] & r_d[j]) | (~(w_x[j] ^ r_d[j]) & bin);
      end
    end
    w_bout    = bin;
    w_qbit    = r_rem[W-1] | ~w_bout;
    w_rem_nxt = w_qbit ? w_diff : w_x;
    w_q_nxt         = r_qacc;
    w_q_nxt[r_i]    = w_qbit;
  end

  // Datapath and result registers; results are loaded on entry to DONE
  // so they are already visible while valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nlo  <= '0;
      r_d    <= '0;
      r_rem  <= '0;
      r_i    <= '0;
      r_qacc <= '0;
      r_ovfn <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
`ifdef APPROX_DIV_RUNTIME_EXACT_EN
      r_exact <= 1'b0;
`endif
    end else if (w_accept) begin
      r_nlo  <= n[W-1:0];
      r_d    <= d;
      r_rem  <= n[2*W-1:W];
      r_i    <= IW'(W-1);
      r_qacc <= '0;
      r_ovfn <= (n[2*W-1:W] >= d);
`ifdef APPROX_DIV_RUNTIME_EXACT_EN
      r_exact <= exact_mode;
`endif
      if (d == '0) begin
        r_q   <= '1;
        r_r   <= n[W-1:0];
        r_dz  <= 1'b1;
        r_ovf <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_qacc <= w_q_nxt;
      r_rem  <= w_rem_nxt;
      if (w_last) begin
        r_q   <= w_q_nxt;
        r_r   <= w_rem_nxt;
        r_dz  <= 1'b0;
        r_ovf <= r_ovfn;
      end else begin
        r_i <= r_i - 1'b1;
      end
    end
  end

  assign ready = (r_state == IDLE);
  assign valid = (r_state == DONE);
  assign q     = r_q;
  assign r     = r_r;
  assign dz    = r_dz;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_seq_approx_row_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_approx_row_divider
//   Directed bench for seq_approx_row_divider. Two instances share clock,
//   reset and operands: dut_a uses the default approximation map, dut_e is
//   built with APPROX_ROWS=0 (fully exact).
// ---------------------------------------------------------------------------
module tb_seq_approx_row_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_e = 1'b0;
  logic [15:0] n_i = '0;
  logic [7:0]  d_i = '0;
  logic        ready_a, valid_a, dz_a, ovf_a;
  logic        ready_e, valid_e, dz_e, ovf_e;
  logic [7:0]  q_a, r_a, q_e, r_e;

  int total = 0;
  int bad   = 0;
  int lat;
  bit sawv;
  logic [15:0] rn;
  logic [7:0]  rd;

  always #5 clk = ~clk;

  seq_approx_row_divider #(.W(8), .APPROX_ROWS(6), .APPROX_COLS(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef APPROX_DIV_RUNTIME_EXACT_EN
    .exact_mode(1'b0),
`endif
    .start(start_a), .n(n_i), .d(d_i),
    .ready(ready_a), .valid(valid_a), .q(q_a), .r(r_a), .dz(dz_a), .ovf(ovf_a)
  );

  seq_approx_row_divider #(.W(8), .APPROX_ROWS(0), .APPROX_COLS(8)) dut_e (
    .clk(clk), .rst_n(rst_n),
`ifdef APPROX_DIV_RUNTIME_EXACT_EN
    .exact_mode(1'b1),
`endif
    .start(start_e), .n(n_i), .d(d_i),
    .ready(ready_e), .valid(valid_e), .q(q_e), .r(r_e), .dz(dz_e), .ovf(ovf_e)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE and return the number of edges, counted
  // from the accepting edge, until valid is seen (40 means it never came).
  task automatic op(input bit sel, input logic [15:0] nn, input logic [7:0] dd,
                    output int lt);
    n_i = nn;
    d_i = dd;
    if (sel) start_e = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_e = 1'b0;
    lt = 1;
    while (!(sel ? valid_e : valid_a) && lt < 40) begin
      @(posedge clk); #1;
      lt++;
    end
  endtask

  initial begin
    // reset state
    #12;
    check("rst_ready", ready_a, 1);
    check("rst_valid", valid_a, 0);
    check("rst_q", q_a, 0);
    check("rst_r", r_a, 0);
    check("rst_dz", dz_a, 0);
    check("rst_ovf", ovf_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // approximate rows force low quotient bits to 1
    op(0, 16'h0000, 8'd5, lat);
    check("apx_lat", lat, 9);
    check("apx_q", q_a, 8'h3F);
    check("apx_r", r_a, 8'h05);
    check("apx_dz", dz_a, 0);
    check("apx_ovf", ovf_a, 0);
    @(posedge clk); #1;
    check("apx_valid_once", valid_a, 0);
    check("apx_ready_back", ready_a, 1);

    // exact division
    op(1, 16'd100, 8'd7, lat);
    check("ex_lat", lat, 9);
    check("ex_q", q_e, 14);
    check("ex_r", r_e, 2);
    check("ex_ovf", ovf_e, 0);
    @(posedge clk); #1;

    // overflow: high half >= divisor
    op(1, 16'h0900, 8'd8, lat);
    check("ovf_lat", lat, 9);
    check("ovf_flag", ovf_e, 1);
    check("ovf_dz", dz_e, 0);
    @(posedge clk); #1;

    // divide by zero
    op(0, 16'h1234, 8'd0, lat);
    check("dz_lat", lat, 1);
    check("dz_flag", dz_a, 1);
    check("dz_ovf", ovf_a, 1);
    check("dz_q", q_a, 8'hFF);
    check("dz_r", r_a, 8'h34);
    @(posedge clk); #1;
    check("dz_valid_once", valid_a, 0);

    // back-to-back: second start in the cycle after valid
    op(1, 16'h0FA3, 8'h11, lat);
    check("b2b1_q", q_e, 8'(16'h0FA3 / 16'h11));
    check("b2b1_r", r_e, 8'(16'h0FA3 % 16'h11));
    @(posedge clk); #1;
    check("b2b_ready", ready_e, 1);
    op(1, 16'h00FF, 8'd3, lat);
    check("b2b2_lat", lat, 9);
    check("b2b2_q", q_e, 85);
    check("b2b2_r", r_e, 0);
    @(posedge clk); #1;
    check("b2b2_valid_once", valid_e, 0);

    // start while busy is ignored
    n_i = 16'd100; d_i = 8'd7; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("busy_ready", ready_e, 0);
    n_i = 16'h00FF; d_i = 8'h01; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    lat = 5;
    while (!valid_e && lat < 40) begin @(posedge clk); #1; lat++; end
    check("busy_lat", lat, 9);
    check("busy_q", q_e, 14);
    check("busy_r", r_e, 2);
    @(posedge clk); #1;
    check("busy_idle1", ready_e, 1);
    @(posedge clk); #1;
    check("busy_idle2", ready_e, 1);

    // reset in the middle of an operation
    n_i = 16'h1234; d_i = 8'h56; start_a = 1'b1; start_e = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_e = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", q_e, 0);
    check("mid_rst_r", r_e, 0);
    check("mid_rst_ready", ready_a, 1);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_ovf", ovf_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sawv = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid_a || valid_e) sawv = 1'b1;
    end
    check("mid_rst_no_valid", sawv, 0);
    check("mid_rst_ready_after", ready_a, 1);

    // random sweep against golden integer division, ovf=0 region
    for (int k = 0; k < 1000; k++) begin
      rd = 8'($urandom_range(255, 1));
      rn = 16'($urandom_range(int'(rd) * 256 - 1, 0));
      op(1, rn, rd, lat);
      check("sweep_q", q_e, 8'(rn / 16'(rd)));
      check("sweep_r", r_e, 8'(rn % 16'(rd)));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
